// File: rtl/aes_block_packer.sv
// Packs a stream of IN_W-bit words MSB-first into 128-bit AES blocks.
// A block is released when full or when in_last closes a short final block.
module aes_block_packer #(
    parameter int IN_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] in_data,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    output logic [127:0]    data_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_nbytes,
    output logic            out_last
);

    localparam int WORDS = 128 / IN_W;
    localparam int CW    = $clog2(WORDS) + 1;
    localparam int BPW   = IN_W / 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [127:0]    blk;
    logic [4:0]      nbytes;
    logic            last_flag;

    logic            accept;
    logic            complete;
    logic            release_blk;
    logic [4:0]      nbytes_fill;

    assign accept      = in_valid && in_ready;
    assign complete    = accept && ((cnt == CW'(WORDS - 1)) || in_last);
    assign release_blk = out_valid && out_ready;
    // cnt still holds the index of the completing word, so +1 gives the word count
    assign nbytes_fill = 5'((int'(cnt) + 1) * BPW);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (complete)    state_nxt = HOLD;
            HOLD: if (release_blk) state_nxt = FILL;
            default:               state_nxt = FILL;
        endcase
    end

    // Output decode; in_ready is forced low for as long as reset is held
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            FILL:    in_ready  = !rst;
            HOLD:    out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Block assembly; clearing on release leaves unfilled slots zero for short blocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            blk       <= '0;
            nbytes    <= '0;
            last_flag <= 1'b0;
        end else if (state == HOLD) begin
            if (out_ready) begin
                cnt       <= '0;
                blk       <= '0;
                nbytes    <= '0;
                last_flag <= 1'b0;
            end
        end else if (accept) begin
            for (int k = 0; k < WORDS; k++) begin
                if (cnt == CW'(k)) blk[127 - k*IN_W -: IN_W] <= in_data;
            end
            cnt <= cnt + CW'(1);
            if (complete) begin
                nbytes    <= nbytes_fill;
                last_flag <= in_last;
            end
        end
    end

    assign data_out   = blk;
    assign out_nbytes = nbytes;
    assign out_last   = last_flag;

    a_nonempty: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> (out_nbytes != 5'd0 && out_nbytes <= 5'd16));
    a_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(out_valid && in_ready));
    a_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> ($stable(data_out) && $stable(out_nbytes) && $stable(out_last)));

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed-vector bench for aes_block_packer across word widths 8/16/32/64/128.
module tb_aes_block_packer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]  d32 = '0;  logic v32 = 0, l32 = 0, r32, ov32, or32 = 0, ol32;  logic [127:0] q32;  logic [4:0] n32;
    logic [7:0]   d8  = '0;  logic v8  = 0, l8  = 0, r8,  ov8,  or8  = 0, ol8;   logic [127:0] q8;   logic [4:0] n8;
    logic [15:0]  d16 = '0;  logic v16 = 0, l16 = 0, r16, ov16, or16 = 0, ol16;  logic [127:0] q16;  logic [4:0] n16;
    logic [63:0]  d64 = '0;  logic v64 = 0, l64 = 0, r64, ov64, or64 = 0, ol64;  logic [127:0] q64;  logic [4:0] n64;
    logic [127:0] d128 = '0; logic v128 = 0, l128 = 0, r128, ov128, or128 = 0, ol128; logic [127:0] q128; logic [4:0] n128;

    aes_block_packer #(.IN_W(32)) u32 (.clk(clk), .rst(rst), .in_data(d32), .in_valid(v32), .in_last(l32),
        .in_ready(r32), .data_out(q32), .out_valid(ov32), .out_ready(or32), .out_nbytes(n32), .out_last(ol32));
    aes_block_packer #(.IN_W(8)) u8 (.clk(clk), .rst(rst), .in_data(d8), .in_valid(v8), .in_last(l8),
        .in_ready(r8), .data_out(q8), .out_valid(ov8), .out_ready(or8), .out_nbytes(n8), .out_last(ol8));
    aes_block_packer #(.IN_W(16)) u16 (.clk(clk), .rst(rst), .in_data(d16), .in_valid(v16), .in_last(l16),
        .in_ready(r16), .data_out(q16), .out_valid(ov16), .out_ready(or16), .out_nbytes(n16), .out_last(ol16));
    aes_block_packer #(.IN_W(64)) u64 (.clk(clk), .rst(rst), .in_data(d64), .in_valid(v64), .in_last(l64),
        .in_ready(r64), .data_out(q64), .out_valid(ov64), .out_ready(or64), .out_nbytes(n64), .out_last(ol64));
    aes_block_packer #(.IN_W(128)) u128 (.clk(clk), .rst(rst), .in_data(d128), .in_valid(v128), .in_last(l128),
        .in_ready(r128), .data_out(q128), .out_valid(ov128), .out_ready(or128), .out_nbytes(n128), .out_last(ol128));

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [0:3][31:0] w;
        int               n;
        logic             last;
        logic [127:0]     data;
        logic [4:0]       nbytes;
        logic             elast;
    } vec_t;

    vec_t vecs [5];

    // Feed one block on consecutive cycles, check it, then hand it off
    task automatic apply32(input vec_t v, input string name);
        for (int i = 0; i < v.n; i++) begin
            v32 = 1'b1;
            d32 = v.w[i];
            l32 = v.last && (i == v.n - 1);
            @(negedge clk);
        end
        v32 = 1'b0;
        l32 = 1'b0;
        chk({name, ".valid"},  ov32, 1);
        chk({name, ".data"},   q32,  v.data);
        chk({name, ".nbytes"}, n32,  v.nbytes);
        chk({name, ".last"},   ol32, v.elast);
        chk({name, ".ready"},  r32,  0);
        or32 = 1'b1;
        @(negedge clk);
        or32 = 1'b0;
        chk({name, ".post_valid"}, ov32, 0);
        chk({name, ".post_data"},  q32,  0);
        chk({name, ".post_ready"}, r32,  1);
    endtask

    logic [127:0]     exp_q [$];
    logic [4:0]       expn_q [$];
    logic             expl_q [$];
    logic [0:3][31:0] cur_w;
    int               cur_n;
    logic             cur_last;
    logic [127:0]     e;

    initial begin
        vecs[0] = '{{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF}, 4, 1'b0,
                    128'h00112233445566778899AABBCCDDEEFF, 5'd16, 1'b0};
        vecs[1] = '{{32'hDEADBEEF, 32'h01234567, 32'h0, 32'h0}, 2, 1'b1,
                    128'hDEADBEEF012345670000000000000000, 5'd8, 1'b1};
        vecs[2] = '{{32'hCAFEF00D, 32'h0, 32'h0, 32'h0}, 1, 1'b1,
                    128'hCAFEF00D000000000000000000000000, 5'd4, 1'b1};
        vecs[3] = '{{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 4, 1'b1,
                    128'h11111111222222223333333344444444, 5'd16, 1'b1};
        vecs[4] = '{{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'h0}, 3, 1'b1,
                    128'hA5A5A5A55A5A5A5A0F0F0F0F00000000, 5'd12, 1'b1};

        // Reset state
        #3;
        chk("rst.in_ready",  r32,  0);
        chk("rst.out_valid", ov32, 0);
        chk("rst.data",      q32,  0);
        chk("rst.nbytes",    n32,  0);
        chk("rst.last",      ol32, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst.first_ready", r32, 1);
        @(negedge clk);

        foreach (vecs[i]) apply32(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: words offered while holding must not leak into the next block
        for (int i = 0; i < 4; i++) begin
            v32 = 1'b1; d32 = vecs[0].w[i]; @(negedge clk);
        end
        for (int c = 0; c < 5; c++) begin
            v32 = 1'b1; d32 = 32'hBAD00000 + c; l32 = 1'b1; or32 = 1'b0;
            @(negedge clk);
            chk("bp.data",  q32,  vecs[0].data);
            chk("bp.ready", r32,  0);
            chk("bp.valid", ov32, 1);
        end
        or32 = 1'b1;
        @(negedge clk);
        v32 = 1'b0; l32 = 1'b0; or32 = 1'b0;
        chk("bp.cleared", q32,  0);
        chk("bp.nbytes",  n32,  0);
        chk("bp.valid0",  ov32, 0);
        apply32(vecs[1], "bp.next");

        // Asynchronous reset mid-fill at IN_W=8
        for (int i = 0; i < 7; i++) begin
            v8 = 1'b1; d8 = 8'hA0 + 8'(i); @(negedge clk);
        end
        v8 = 1'b0;
        chk("mid.partial", q8, {56'hA0A1A2A3A4A5A6, 72'h0});
        #2 rst = 1'b1;
        #1;
        chk("mid.data",   q8,  0);
        chk("mid.ready",  r8,  0);
        chk("mid.valid",  ov8, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid.no_block", ov8, 0);
        for (int i = 0; i < 16; i++) begin
            v8 = 1'b1; d8 = 8'(i); @(negedge clk);
        end
        v8 = 1'b0;
        chk("mid.valid2", ov8, 1);
        chk("mid.block",  q8,  128'h000102030405060708090A0B0C0D0E0F);
        chk("mid.nbytes", n8,  16);
        chk("mid.last",   ol8, 0);
        or8 = 1'b1; @(negedge clk); or8 = 1'b0;
        chk("mid.release", ov8, 0);

        // Width sweep with in_last on the first word
        v8 = 1; l8 = 1; d8 = 8'h5A;
        v16 = 1; l16 = 1; d16 = 16'hBEEF;
        v64 = 1; l64 = 1; d64 = 64'h0123456789ABCDEF;
        v128 = 1; l128 = 1; d128 = 128'hFEDCBA9876543210_0F1E2D3C4B5A6978;
        @(negedge clk);
        v8 = 0; l8 = 0; v16 = 0; l16 = 0; v64 = 0; l64 = 0; v128 = 0; l128 = 0;
        chk("sw8.nbytes",   n8,   1);
        chk("sw8.data",     q8,   {8'h5A, 120'h0});
        chk("sw16.nbytes",  n16,  2);
        chk("sw16.data",    q16,  {16'hBEEF, 112'h0});
        chk("sw64.nbytes",  n64,  8);
        chk("sw64.data",    q64,  {64'h0123456789ABCDEF, 64'h0});
        chk("sw128.nbytes", n128, 16);
        chk("sw128.data",   q128, 128'hFEDCBA9876543210_0F1E2D3C4B5A6978);
        chk("sw.last",      {ol8, ol16, ol64, ol128}, 4'hF);
        chk("sw.valid",     {ov8, ov16, ov64, ov128}, 4'hF);
        or8 = 1; or16 = 1; or64 = 1; or128 = 1;
        @(negedge clk);
        or8 = 0; or16 = 0; or64 = 0; or128 = 0;
        chk("sw.released", {ov8, ov16, ov64, ov128}, 4'h0);

        // IN_W=128 without in_last still completes every word
        v128 = 1; d128 = 128'h1; @(negedge clk); v128 = 0;
        chk("w128.nbytes", n128,  16);
        chk("w128.last",   ol128, 0);
        or128 = 1; @(negedge clk); or128 = 0;

        // Random valid/ready gaps over 1000 blocks, scoreboarded
        begin
            int sent = 0, rcvd = 0, widx = 0, cyc = 0;
            cur_n = $urandom_range(1, 4);
            cur_last = (cur_n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) cur_w[i] = $urandom;
            while (rcvd < 1000 && cyc < 60000) begin
                or32 = ($urandom_range(0, 3) != 0);
                if (sent < 1000) begin
                    v32 = ($urandom_range(0, 3) != 0);
                    d32 = cur_w[widx];
                    l32 = cur_last && (widx == cur_n - 1);
                end else begin
                    v32 = 1'b0; l32 = 1'b0;
                end
                if (ov32 && or32) begin
                    if (exp_q.size() == 0) begin
                        chk("rnd.unexpected", 1, 0);
                    end else begin
                        chk("rnd.data",   q32,  exp_q.pop_front());
                        chk("rnd.nbytes", n32,  expn_q.pop_front());
                        chk("rnd.last",   ol32, expl_q.pop_front());
                    end
                    rcvd++;
                end
                if (v32 && r32) begin
                    widx++;
                    if (widx == cur_n) begin
                        e = '0;
                        for (int i = 0; i < cur_n; i++) e[127 - 32*i -: 32] = cur_w[i];
                        exp_q.push_back(e);
                        expn_q.push_back(5'(4 * cur_n));
                        expl_q.push_back(cur_last);
                        sent++;
                        widx = 0;
                        cur_n = $urandom_range(1, 4);
                        cur_last = (cur_n < 4) ? 1'b1 : 1'($urandom_range(0, 1));
                        for (int i = 0; i < 4; i++) cur_w[i] = $urandom;
                    end
                end
                @(negedge clk);
                cyc++;
            end
            v32 = 1'b0; l32 = 1'b0; or32 = 1'b0;
            chk("rnd.blocks_received", 128'(rcvd), 128'd1000);
            chk("rnd.queue_empty", 128'(exp_q.size()), 128'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/aes_block_packer.md
AES_BLOCK_PACKER -- requirements
Module: aes_block_packer

Interface
REQ-001 SHALL have parameter IN_W, default 32, meaning input word width in bits; legal values are 8, 16, 32, 64 and 128.
REQ-002 SHALL derive localparam WORDS = 128/IN_W, the number of input words per 128-bit AES block.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_data, input, IN_W bits: input word.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_last, input, 1 bit: the current word is the final word of the message.
REQ-008 SHALL have port in_ready, output, 1 bit: the packer accepts a word this cycle.
REQ-009 SHALL have port data_out, output, 128 bits: the packed AES block.
REQ-010 SHALL have port out_valid, output, 1 bit: data_out holds a complete block.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream AES core takes the block.
REQ-012 SHALL have port out_nbytes, output, 5 bits: count of valid bytes in data_out, range 1..16.
REQ-013 SHALL have port out_last, output, 1 bit: data_out holds the final block of the message.

Function
REQ-014 SHALL implement a two-state FSM with states FILL and HOLD.
REQ-015 In FILL: in_ready=1 and out_valid=0. In HOLD: in_ready=0 and out_valid=1.
REQ-016 SHALL accept a word only when in_valid && in_ready; in_data and in_last are ignored otherwise.
REQ-017 SHALL pack words MSB-first: accepted word k (0-based) goes to data_out[127-k*IN_W -: IN_W].
REQ-018 SHALL keep a word counter cnt, width clog2(WORDS)+1, cleared on entry to FILL and incremented on each accept.
REQ-019 On an accept with cnt==WORDS-1 or in_last==1, SHALL transition FILL->HOLD and assert out_valid on the next cycle.
- Latency: one cycle from the completing accept to out_valid.
REQ-020 On entering HOLD: out_nbytes=(cnt+1)*IN_W/8 for the completing word; out_last=in_last of that word.
REQ-021 Short final block: unfilled low-order bits of data_out SHALL be zero.
REQ-022 In HOLD, data_out, out_nbytes and out_last SHALL stay stable while out_ready=0, for any number of cycles.
REQ-023 On out_valid && out_ready, SHALL transition HOLD->FILL next cycle.
- The same edge clears data_out, cnt, out_nbytes and out_last.
- No input is accepted in that cycle.
REQ-024 IN_W=128: every accept SHALL complete a block (WORDS=1); out_nbytes=16.
REQ-025 An in_last arriving on the WORDS-th word SHALL produce a single full block with out_last=1, not an extra empty block.
REQ-026 SHALL never emit a block with zero valid bytes.
REQ-027 in_valid may be low in any cycle; a partially filled block SHALL be held indefinitely until filled or terminated by in_last.

Reset
REQ-028 While rst=1, independent of clk: state=FILL, cnt=0, data_out=0, out_valid=0, out_nbytes=0, out_last=0; in_ready SHALL be 0 while rst is asserted.
REQ-029 Reset asserted mid-FILL or mid-HOLD SHALL discard any partial or pending block; no block is output after reset deassertion until newly accepted words complete one.
REQ-030 After rst deasserts, in_ready SHALL be 1 on the first rising edge.

Verification
REQ-031 Full block, IN_W=32: accept 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on consecutive cycles -> next cycle data_out=0x00112233445566778899AABBCCDDEEFF, out_nbytes=16, out_last=0, out_valid=1.
REQ-032 Short final block, IN_W=32: accept 0xDEADBEEF, then 0x01234567 with in_last=1 -> data_out=0xDEADBEEF012345670000000000000000, out_nbytes=8, out_last=1.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> data_out stable and in_ready=0 throughout; on out_ready=1 -> handshake, then FILL next cycle with data_out=0.
REQ-034 Reset mid-fill, IN_W=8: accept 7 bytes, pulse rst asynchronously between edges -> outputs zero immediately; then 16 bytes 0x00..0x0F -> data_out=0x000102030405060708090A0B0C0D0E0F, out_nbytes=16.
REQ-035 Sweep IN_W=8/16/64/128 with in_last on the first word -> out_nbytes=1/2/8/16 respectively, remaining bits zero.
REQ-036 Random valid/ready gaps over 1000 blocks -> output blocks match a reference model word-for-word; no word is lost or duplicated.
